// File: rtl/axi_rd_arbiter.sv
// Two-requester AXI read-channel arbiter (port 0 icache, port 1 LSU), one outstanding burst.
// Define AXI_RD_ARB_RR_EN for round-robin tie-breaking; default is fixed priority m1 > m0.
module axi_rd_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int LW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_arvalid,
  input  logic [AW-1:0] m0_araddr,
  input  logic [LW-1:0] m0_arlen,
  output logic          m0_arready,
  output logic [DW-1:0] m0_rdata,
  output logic [1:0]    m0_rresp,
  output logic          m0_rvalid,
  output logic          m0_rlast,
  input  logic          m0_rready,
  input  logic          m1_arvalid,
  input  logic [AW-1:0] m1_araddr,
  input  logic [LW-1:0] m1_arlen,
  output logic          m1_arready,
  output logic [DW-1:0] m1_rdata,
  output logic [1:0]    m1_rresp,
  output logic          m1_rvalid,
  output logic          m1_rlast,
  input  logic          m1_rready,
  output logic          axi_arvalid,
  output logic [AW-1:0] axi_araddr,
  output logic [LW-1:0] axi_arlen,
  input  logic          axi_arready,
  input  logic [DW-1:0] axi_rdata,
  input  logic [1:0]    axi_rresp,
  input  logic          axi_rvalid,
  output logic          axi_rready
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic          win1, gnt0, gnt1;
  logic          in_data, sel0, sel1, own_rready, beat_last, r_hs;

`ifdef AXI_RD_ARB_RR_EN
  logic lg_q, lg_d;

  // Tie goes to whichever port was not granted last; lone requester always wins.
  always_comb win1 = m1_arvalid & (~m0_arvalid | ~lg_q);

  always_comb begin
    lg_d = lg_q;
    if (gnt0 | gnt1) lg_d = gnt1;
  end

  always_ff @(posedge clk) begin
    if (rst) lg_q <= 1'b1;
    else     lg_q <= lg_d;
  end
`else
  always_comb win1 = m1_arvalid;
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    case (state_q)
      IDLE: begin
        if (m0_arvalid | m1_arvalid) begin
          gnt1    = win1;
          gnt0    = ~win1;
          owner_d = win1;
          addr_d  = win1 ? m1_araddr : m0_araddr;
          len_d   = win1 ? m1_arlen  : m0_arlen;
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (axi_arready) begin
          cnt_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        // Burst end comes from our own beat count; slave rlast is not trusted.
        if (r_hs) begin
          if (beat_last) state_d = IDLE;
          else           cnt_d   = cnt_q + LW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_data    = (state_q == DATA);
  assign sel0       = in_data & ~owner_q;
  assign sel1       = in_data & owner_q;
  assign own_rready = owner_q ? m1_rready : m0_rready;
  assign beat_last  = (cnt_q == len_q);
  assign r_hs       = axi_rvalid & axi_rready;

  assign m0_arready  = gnt0;
  assign m1_arready  = gnt1;
  assign axi_arvalid = (state_q == ADDR);
  assign axi_araddr  = addr_q;
  assign axi_arlen   = len_q;
  assign axi_rready  = in_data & own_rready;

  assign m0_rvalid = sel0 & axi_rvalid;
  assign m0_rlast  = sel0 & axi_rvalid & beat_last;
  assign m0_rdata  = sel0 ? axi_rdata : '0;
  assign m0_rresp  = sel0 ? axi_rresp : 2'b00;
  assign m1_rvalid = sel1 & axi_rvalid;
  assign m1_rlast  = sel1 & axi_rvalid & beat_last;
  assign m1_rdata  = sel1 ? axi_rdata : '0;
  assign m1_rresp  = sel1 ? axi_rresp : 2'b00;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Scoreboard bench for axi_rd_arbiter: random requesters and slave, expectations from a
// transaction-level model of the arbitration and burst rules.
module tb_axi_rd_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          m0_arvalid = 0, m1_arvalid = 0;
  logic [AW-1:0] m0_araddr = 0, m1_araddr = 0;
  logic [LW-1:0] m0_arlen = 0, m1_arlen = 0;
  logic          m0_arready, m1_arready;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic [1:0]    m0_rresp, m1_rresp;
  logic          m0_rvalid, m1_rvalid, m0_rlast, m1_rlast;
  logic          m0_rready = 0, m1_rready = 0;
  logic          axi_arvalid, axi_rready;
  logic [AW-1:0] axi_araddr;
  logic [LW-1:0] axi_arlen;
  logic          axi_arready = 0, axi_rvalid = 0;
  logic [DW-1:0] axi_rdata = 0;
  logic [1:0]    axi_rresp = 0;

  axi_rd_arbiter #(.AW(AW), .DW(DW), .LW(LW)) dut (
    .clk(clk), .rst(rst),
    .m0_arvalid(m0_arvalid), .m0_araddr(m0_araddr), .m0_arlen(m0_arlen), .m0_arready(m0_arready),
    .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rlast(m0_rlast),
    .m0_rready(m0_rready),
    .m1_arvalid(m1_arvalid), .m1_araddr(m1_araddr), .m1_arlen(m1_arlen), .m1_arready(m1_arready),
    .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rlast(m1_rlast),
    .m1_rready(m1_rready),
    .axi_arvalid(axi_arvalid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
    .axi_arready(axi_arready), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready)
  );

  typedef struct { bit port; logic [AW-1:0] addr; logic [LW-1:0] len; } txn_t;
  typedef struct { logic [DW-1:0] data; logic [1:0] resp; } beat_t;

  txn_t  gq[$];  // expected grants, in order
  txn_t  aq[$];  // granted, awaiting AR handshake
  txn_t  bq[$];  // burst in flight
  beat_t sbq[$]; // beats presented by the slave
  int    total = 0, bad = 0;
  int    bidx = 0;
  bit    gnt_due = 0;
  bit    lg = 1;   // model: last granted port, used only when round-robin is built

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Arbitration rule: single requester wins; on a tie, fixed m1 or round-robin.
  function automatic bit pick(bit p0, bit p1);
    bit w;
    if (p0 && !p1)      w = 0;
    else if (p1 && !p0) w = 1;
    else begin
`ifdef AXI_RD_ARB_RR_EN
      w = ~lg;
`else
      w = 1;
`endif
    end
    lg = w;
    return w;
  endfunction

  task automatic push_pick(bit p0, bit p1, logic [AW-1:0] a0, logic [AW-1:0] a1,
                           logic [LW-1:0] l0, logic [LW-1:0] l1);
    txn_t t;
    t.port = pick(p0, p1);
    t.addr = t.port ? a1 : a0;
    t.len  = t.port ? l1 : l0;
    gq.push_back(t);
  endtask

  // Monitor
  always @(negedge clk) begin
    txn_t t;
    bit ev0, ev1, el0, el1, own;
    if (rst) begin
      aq.delete(); bq.delete(); sbq.delete(); bidx = 0; gnt_due = 0;
    end else begin
      chk("axi_arvalid", axi_arvalid, aq.size() != 0);
      if (gnt_due) chk("regrant_next_cycle", m0_arready | m1_arready, 1);
      gnt_due = 0;
      own = (bq.size() != 0) ? bq[0].port : 1'b0;
      ev0 = axi_rvalid && bq.size() != 0 && !own;
      ev1 = axi_rvalid && bq.size() != 0 && own;
      el0 = ev0 && bidx == int'(bq[0].len);
      el1 = ev1 && bidx == int'(bq[0].len);
      chk("m0_rvalid", m0_rvalid, ev0);
      chk("m1_rvalid", m1_rvalid, ev1);
      chk("m0_rlast", m0_rlast, el0);
      chk("m1_rlast", m1_rlast, el1);
      chk("axi_rready", axi_rready, bq.size() != 0 && (own ? m1_rready : m0_rready));
      if (bq.size() != 0 && axi_rvalid) begin
        if (sbq.size() == 0) begin
          total++; bad++;
          $display("FAIL beat_unexpected got=%0h exp=none", axi_rdata);
        end else begin
          chk("rdata", own ? m1_rdata : m0_rdata, sbq[0].data);
          chk("rresp", own ? m1_rresp : m0_rresp, sbq[0].resp);
          if (axi_rready) begin
            void'(sbq.pop_front());
            if (bidx == int'(bq[0].len)) begin
              void'(bq.pop_front());
              bidx = 0;
              gnt_due = m0_arvalid | m1_arvalid;
            end else bidx++;
          end
        end
      end
      if (axi_arvalid && axi_arready && aq.size() != 0) begin
        t = aq.pop_front();
        chk("axi_araddr", axi_araddr, t.addr);
        chk("axi_arlen", axi_arlen, t.len);
        bq.push_back(t);
      end
      if (m0_arready || m1_arready) begin
        chk("single_grant", m0_arready & m1_arready, 0);
        chk("grant_when_busy", aq.size() + bq.size(), 0);
        if (gq.size() == 0) begin
          total++; bad++;
          $display("FAIL grant_unexpected got=%0b%0b exp=none", m1_arready, m0_arready);
        end else begin
          t = gq.pop_front();
          chk("grant_port", m1_arready, t.port);
          aq.push_back(t);
        end
      end
    end
  end

  // Requester rready, random backpressure
  initial forever begin
    @(posedge clk); #1;
    m0_rready = ($urandom % 4) != 0;
    m1_rready = ($urandom % 4) != 0;
  end

  // Slave: samples at negedge, drives just after posedge
  initial begin
    int st = 0, dly = -1, left = 0;
    bit s_rst, har, arv, hr;
    logic [LW-1:0] ln;
    beat_t b;
    forever begin
      @(negedge clk);
      s_rst = rst; har = axi_arvalid && axi_arready; arv = axi_arvalid;
      hr = axi_rvalid && axi_rready; ln = axi_arlen;
      @(posedge clk); #1;
      if (s_rst) begin
        st = 0; dly = -1; axi_arready = 0; axi_rvalid = 0;
      end else if (st == 0) begin
        if (har) begin
          axi_arready = 0; st = 1; left = int'(ln) + 1; dly = -1;
        end else if (arv) begin
          if (dly < 0) dly = $urandom % 4;
          if (dly == 0) axi_arready = 1;
          else dly--;
        end
      end else begin
        if (hr) begin axi_rvalid = 0; left--; end
        if (left == 0) st = 0;
        else if (!axi_rvalid && ($urandom % 3) != 0) begin
          axi_rvalid = 1; axi_rdata = $urandom; axi_rresp = 2'($urandom % 4);
          b.data = axi_rdata; b.resp = axi_rresp;
          sbq.push_back(b);
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1; m0_arvalid = 0; m1_arvalid = 0;
    gq.delete(); lg = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  task automatic round(bit r0, bit r1, logic [AW-1:0] a0, logic [AW-1:0] a1,
                       logic [LW-1:0] l0, logic [LW-1:0] l1);
    bit p0 = r0, p1 = r1, g0, g1;
    int cyc = 0;
    @(posedge clk); #1;
    m0_arvalid = r0; m0_araddr = a0; m0_arlen = l0;
    m1_arvalid = r1; m1_araddr = a1; m1_arlen = l1;
    push_pick(p0, p1, a0, a1, l0, l1);
    while ((p0 || p1) && cyc < 3000) begin
      @(negedge clk); cyc++;
      g0 = m0_arready; g1 = m1_arready;
      @(posedge clk); #1;
      if (g0) begin p0 = 0; m0_arvalid = 0; end
      if (g1) begin p1 = 0; m1_arvalid = 0; end
      if ((g0 || g1) && (p0 || p1)) push_pick(p0, p1, a0, a1, l0, l1);
    end
    while ((gq.size() != 0 || aq.size() != 0 || bq.size() != 0) && cyc < 3000) begin
      @(negedge clk); cyc++;
    end
    if (cyc >= 3000) begin
      total++; bad++;
      $display("FAIL round_timeout got=%0d exp=<3000", cyc);
      do_reset();
    end
  endtask

  initial begin
    int cyc;
    bit r0, r1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_m0_arready", m0_arready, 0);
    chk("rst_m1_arready", m1_arready, 0);
    chk("rst_rvalid", {m0_rvalid, m1_rvalid, m0_rlast, m1_rlast}, 0);
    chk("rst_axi_ar", {axi_arvalid, axi_rready}, 0);
    chk("rst_axi_addr_len", {axi_araddr, axi_arlen}, 0);
    @(posedge clk); #1 rst = 0;

    round(1, 0, 32'h8000_0040, 32'h0, 8'd3, 8'd0);
    round(1, 1, 32'h1000_0000, 32'ha000_0000, 8'd2, 8'd0);
    repeat (2) round(1, 1, 32'h2000_0000, 32'hb000_0000, 8'd0, 8'd0);
    round(1, 0, 32'h3000_0000, 32'h0, 8'd255, 8'd0);
    round(0, 1, 32'h0, 32'hc000_0010, 8'd0, 8'd1);

    // Reset in the middle of a burst
    @(posedge clk); #1;
    m0_arvalid = 1; m0_araddr = 32'h4000_0000; m0_arlen = 8'd3;
    push_pick(1, 0, m0_araddr, 32'h0, m0_arlen, 8'd0);
    cyc = 0;
    while (bidx < 2 && cyc < 500) begin
      @(posedge clk); #1; cyc++;
      if (aq.size() != 0 || bq.size() != 0) m0_arvalid = 0;
    end
    chk("mid_burst_reached", cyc < 500, 1);
    rst = 1; m0_arvalid = 0; gq.delete(); lg = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("mrst_ar", {m0_arready, m1_arready, axi_arvalid, axi_rready}, 0);
    chk("mrst_r", {m0_rvalid, m1_rvalid, m0_rlast, m1_rlast}, 0);
    chk("mrst_addr_len", {axi_araddr, axi_arlen}, 0);
    round(1, 0, 32'h5000_0080, 32'h0, 8'd1, 8'd0);

    repeat (60) begin
      r0 = $urandom % 2; r1 = $urandom % 2;
      if (!r0 && !r1) r0 = 1;
      round(r0, r1, $urandom, $urandom,
            LW'(($urandom % 4 == 0) ? 0 : $urandom % 8),
            LW'(($urandom % 4 == 0) ? 0 : $urandom % 8));
      repeat ($urandom % 3) @(posedge clk);
    end

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
